// File: rtl/adam_pause_chain_pkg.sv
// Shared types and helpers for the ADAM pause-chain controller.
package adam_pause_chain_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    RUN      = 3'd1,
    PAUSING  = 3'd2,
    PAUSED   = 3'd3,
    RESUMING = 3'd4
  } pause_chain_state_t;

  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/adam_pause_chain_ctrl.sv
// Sequences one upstream pause request across NO_UNITS downstream pause ports:
// pause in ascending index order, resume in descending order, with an optional step watchdog.
module adam_pause_chain_ctrl
  import adam_pause_chain_pkg::*;
#(
  parameter  int NO_UNITS     = 4,
  parameter  int TIMEOUT      = 0,
  parameter  bit RESET_PAUSED = 1'b1,
  localparam int IDX_W        = idx_width(NO_UNITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slv_req,
  output logic                slv_ack,
  output logic [NO_UNITS-1:0] mst_req,
  input  logic [NO_UNITS-1:0] mst_ack,
  output logic                err,
  output logic [IDX_W-1:0]    err_idx
);

  localparam int                 TMR_W       = idx_width(TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NO_UNITS - 1);
  localparam logic [TMR_W-1:0]   TMR_MAX     = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam pause_chain_state_t RESET_STATE = pause_chain_state_t'(RESET_PAUSED ? INIT : RUN);

  pause_chain_state_t  state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s, idx_up_s, idx_dn_s;
  logic [TMR_W-1:0]    timer_r, timer_s;
  logic [NO_UNITS-1:0] req_s;
  logic                slv_ack_s, err_s, step_done_s, waiting_s;
  logic [IDX_W-1:0]    err_idx_s;

  // Next-state, next-output and watchdog evaluation.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    idx_up_s    = idx_r + 1'b1;
    idx_dn_s    = idx_r - 1'b1;
    timer_s     = timer_r;
    req_s       = mst_req;
    slv_ack_s   = slv_ack;
    err_s       = err;
    err_idx_s   = err_idx;
    step_done_s = 1'b0;
    waiting_s   = 1'b0;

    case (state_r)
      INIT: begin
        waiting_s = 1'b1;
        if (&mst_ack) begin
          state_s     = PAUSED;
          slv_ack_s   = 1'b1;
          step_done_s = 1'b1;
        end else begin
          state_s = INIT;
        end
      end
      RUN: begin
        if (slv_req) begin
          state_s     = PAUSING;
          idx_s       = '0;
          req_s[0]    = 1'b1;
          step_done_s = 1'b1;
        end else begin
          req_s     = '0;
          slv_ack_s = 1'b0;
        end
      end
      PAUSING: begin
        waiting_s = 1'b1;
        if (mst_ack[idx_r]) begin
          step_done_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_s   = PAUSED;
            slv_ack_s = 1'b1;
          end else begin
            idx_s           = idx_up_s;
            req_s[idx_up_s] = 1'b1;
          end
        end else begin
          req_s[idx_r] = 1'b1;
        end
      end
      PAUSED: begin
        if (!slv_req) begin
          state_s         = RESUMING;
          idx_s           = LAST_IDX;
          req_s[LAST_IDX] = 1'b0;
          step_done_s     = 1'b1;
        end else begin
          req_s     = '1;
          slv_ack_s = 1'b1;
        end
      end
      RESUMING: begin
        waiting_s = 1'b1;
        if (!mst_ack[idx_r]) begin
          step_done_s = 1'b1;
          if (idx_r == '0) begin
            state_s   = RUN;
            slv_ack_s = 1'b0;
          end else begin
            idx_s           = idx_dn_s;
            req_s[idx_dn_s] = 1'b0;
          end
        end else begin
          req_s[idx_r] = 1'b0;
        end
      end
      default: begin
        state_s = RESET_STATE;
      end
    endcase

    // The watchdog only flags a stuck step; it never skips or forces a unit.
    if (step_done_s || !waiting_s) begin
      timer_s = '0;
    end else if ((TIMEOUT > 0) && (timer_r == TMR_MAX)) begin
      err_s = 1'b1;
      if (!err) begin
        err_idx_s = idx_r;
      end else begin
        err_idx_s = err_idx;
      end
    end else if (TIMEOUT > 0) begin
      timer_s = timer_r + 1'b1;
    end else begin
      timer_s = '0;
    end
  end

  // State, step index, watchdog timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
      idx_r   <= '0;
      timer_r <= '0;
      mst_req <= {NO_UNITS{RESET_PAUSED}};
      slv_ack <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      timer_r <= timer_s;
      mst_req <= req_s;
      slv_ack <= slv_ack_s;
      err     <= err_s;
      err_idx <= err_idx_s;
    end
  end

endmodule

// File: tb/tb_adam_pause_chain_ctrl.sv
// Scoreboard bench for adam_pause_chain_ctrl with randomly delayed unit acknowledges.
module tb_adam_pause_chain_ctrl;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          slv_req;
  logic          slv_ack;
  logic [N-1:0]  mst_req;
  logic [N-1:0]  mst_ack;
  logic          err;
  logic [IW-1:0] err_idx;

  int tests = 0;
  int fails = 0;

  // Expected output-change events: {slv_ack, mst_req[3:0], err, err_idx[1:0]}
  logic [7:0] exp_q[$];
  bit free_run  = 1'b0;
  bit fast      = 1'b0;
  int hold_unit = -1;
  int hold_cycles = 20;
  int cnt[N];
  bit pend[N];

  always #5 clk = ~clk;

  adam_pause_chain_ctrl #(
    .NO_UNITS    (N),
    .TIMEOUT     (TO),
    .RESET_PAUSED(1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .slv_req(slv_req),
    .slv_ack(slv_ack),
    .mst_req(mst_req),
    .mst_ack(mst_ack),
    .err    (err),
    .err_idx(err_idx)
  );

  // Unit models: each ack follows its req after a per-transition delay.
  initial begin
    mst_ack = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      cnt[i]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (mst_req[i] !== mst_ack[i]) begin
          if (!pend[i]) begin
            pend[i] = 1'b1;
            if (fast) cnt[i] = 0;
            else if (i == hold_unit) cnt[i] = hold_cycles;
            else cnt[i] = $urandom_range(0, 5);
          end
          if (cnt[i] == 0) begin
            mst_ack[i] = mst_req[i];
            pend[i]    = 1'b0;
          end else begin
            cnt[i] = cnt[i] - 1;
          end
        end else begin
          pend[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: order checks on every output change, scoreboard pop when not free-running.
  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    logic [7:0] expv;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      cur = {slv_ack, mst_req, err, err_idx};
      if (rst_n !== 1'b1) begin
        prev = cur;
      end else if (cur !== prev) begin
        tests++;
        if (((mst_req + 4'd1) & mst_req) != 4'd0) begin
          fails++;
          $display("FAIL thermometer: mst_req=%b is not a contiguous low run", mst_req);
        end
        for (int i = 0; i < N; i++) begin
          if (!prev[3+i] && mst_req[i] && i > 0) begin
            tests++;
            if (mst_ack[i-1] !== 1'b1) begin
              fails++;
              $display("FAIL pause_order: req[%0d] rose with ack[%0d]=%b", i, i-1, mst_ack[i-1]);
            end
          end
          if (prev[3+i] && !mst_req[i] && i < N-1) begin
            tests++;
            if (mst_ack[i+1] !== 1'b0) begin
              fails++;
              $display("FAIL resume_order: req[%0d] fell with ack[%0d]=%b", i, i+1, mst_ack[i+1]);
            end
          end
        end
        if (!prev[7] && slv_ack) begin
          tests++;
          if (mst_ack !== 4'b1111) begin
            fails++;
            $display("FAIL ack_rise: slv_ack rose with mst_ack=%b, required 1111", mst_ack);
          end
        end
        if (prev[7] && !slv_ack) begin
          tests++;
          if (mst_ack[0] !== 1'b0) begin
            fails++;
            $display("FAIL ack_fall: slv_ack fell with mst_ack[0]=%b, required 0", mst_ack[0]);
          end
        end
        if (!free_run) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %b with no expectation queued", cur);
          end else begin
            expv = exp_q.pop_front();
            if (cur !== expv) begin
              fails++;
              $display("FAIL scoreboard: got ack/req/err/idx=%b, required %b", cur, expv);
            end
          end
        end
        prev = cur;
      end
    end
  end

  task automatic push(input logic a, input logic [3:0] r, input logic e, input logic [1:0] ix);
    exp_q.push_back({a, r, e, ix});
  endtask

  task automatic push_pause(input logic e, input logic [1:0] ix);
    push(1'b0, 4'b0001, e, ix);
    push(1'b0, 4'b0011, e, ix);
    push(1'b0, 4'b0111, e, ix);
    push(1'b0, 4'b1111, e, ix);
    push(1'b1, 4'b1111, e, ix);
  endtask

  task automatic push_resume(input logic e, input logic [1:0] ix);
    push(1'b1, 4'b0111, e, ix);
    push(1'b1, 4'b0011, e, ix);
    push(1'b1, 4'b0001, e, ix);
    push(1'b1, 4'b0000, e, ix);
    push(1'b0, 4'b0000, e, ix);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_req(input logic [3:0] v, input int budget);
    int k;
    k = 0;
    while (mst_req !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (mst_req !== v) begin
      fails++;
      $display("FAIL wait_req: mst_req=%b, required %b", mst_req, v);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, failures so far %0d", fails);
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    slv_req = 1'b1;
    fast    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {slv_ack, mst_req, err, err_idx}, {1'b0, 4'b1111, 1'b0, 2'b00});

    // 1: units ack immediately, INIT -> PAUSED within two cycles
    push(1'b1, 4'b1111, 1'b0, 2'b00);
    rst_n = 1'b1;
    n = 0;
    while (!slv_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!slv_ack || n > 2) begin
      fails++;
      $display("FAIL init_latency: slv_ack=%b after %0d cycles, required 1 within 2", slv_ack, n);
    end
    drain("init", 20);
    fast = 1'b0;

    // 3: resume from PAUSED
    push_resume(1'b0, 2'b00);
    slv_req = 1'b0;
    drain("resume", 100);

    // 2: pause from RUN
    push_pause(1'b0, 2'b00);
    slv_req = 1'b1;
    drain("pause", 100);

    // 4: unit 2 withholds its ack for 20 cycles
    push_resume(1'b0, 2'b00);
    slv_req = 1'b0;
    drain("resume_pre_timeout", 100);
    hold_unit = 2;
    push(1'b0, 4'b0001, 1'b0, 2'b00);
    push(1'b0, 4'b0011, 1'b0, 2'b00);
    push(1'b0, 4'b0111, 1'b0, 2'b00);
    push(1'b0, 4'b0111, 1'b1, 2'b10);
    push(1'b0, 4'b1111, 1'b1, 2'b10);
    push(1'b1, 4'b1111, 1'b1, 2'b10);
    slv_req = 1'b1;
    wait_req(4'b0111, 60);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL err_latency: err rose after %0d cycles of step 2, required 16", n);
    end
    drain("timeout_pause", 100);
    hold_unit = -1;
    check("err_sticky", {6'd0, err, err_idx[1]}, {6'd0, 1'b1, 1'b1});

    // 5: slv_req dropped while pausing at idx 1
    push_resume(1'b1, 2'b10);
    slv_req = 1'b0;
    drain("resume_pre_toggle", 100);
    push_pause(1'b1, 2'b10);
    push_resume(1'b1, 2'b10);
    slv_req = 1'b1;
    wait_req(4'b0011, 40);
    slv_req = 1'b0;
    drain("toggle_sequence", 200);

    // 6: reset asserted while resuming at idx 2
    push_pause(1'b1, 2'b10);
    slv_req = 1'b1;
    drain("pause_pre_reset", 100);
    push(1'b1, 4'b0111, 1'b1, 2'b10);
    push(1'b1, 4'b0011, 1'b1, 2'b10);
    slv_req = 1'b0;
    wait_req(4'b0011, 60);
    rst_n   = 1'b0;
    slv_req = 1'b1;
    #1;
    check("mid_reset", {slv_ack, mst_req, err, err_idx}, {1'b0, 4'b1111, 1'b0, 2'b00});
    exp_q.delete();
    repeat (2) @(negedge clk);
    push(1'b1, 4'b1111, 1'b0, 2'b00);
    rst_n = 1'b1;
    drain("post_reset_init", 50);

    // Random slv_req activity with only the order checks active
    free_run = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) slv_req = ~slv_req;
    end
    slv_req = 1'b0;
    n = 0;
    while (!(slv_ack == 1'b0 && mst_req == 4'b0000) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("random_settle", {3'd0, slv_ack, mst_req}, 8'h00);
    check("random_no_err", {7'd0, err}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
